// File: rtl/decode_32.sv
// Minisys decode stage: 32x32 register file, operand reads, immediate extension and write-back.
// Optional macro DECODE32_BYPASS_EN forwards the pending write data onto the read ports.
module decode_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] mem_data,
  input  logic [31:0] ALU_result,
  input  logic [31:0] opcplus4,
  input  logic        Jal,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        RegDst,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic [31:0] Sign_extend
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        zero_ext;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] regs_q [32];

  assign op  = Instruction[31:26];
  assign rs  = Instruction[25:21];
  assign rt  = Instruction[20:16];
  assign rd  = Instruction[15:11];
  assign imm = Instruction[15:0];

  // sltiu/andi/ori/xori take a zero-extended immediate
  assign zero_ext    = (op == 6'h0B) || (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
  assign Sign_extend = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};

  always_comb begin
    wr_addr = rt;
    wr_data = ALU_result;
    if (Jal) begin
      wr_addr = 5'd31;
      wr_data = opcplus4;
    end else begin
      if (RegDst) wr_addr = rd;
      if (MemtoReg) wr_data = mem_data;
    end
  end

  assign wr_en = RegWrite && (wr_addr != 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    read_data_1 = (rs == 5'd0) ? 32'h0 : regs_q[rs];
    read_data_2 = (rt == 5'd0) ? 32'h0 : regs_q[rt];
`ifdef DECODE32_BYPASS_EN
    // reset gates forwarding so a held-off write never leaks onto the read ports
    if (reset && wr_en && (wr_addr == rs)) read_data_1 = wr_data;
    if (reset && wr_en && (wr_addr == rt)) read_data_2 = wr_data;
`endif
  end

endmodule

// File: tb/tb_decode_32.sv
// Self-checking bench for decode_32: register-file model checked every negedge plus directed literals.
module tb_decode_32;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Instruction;
  logic [31:0] mem_data;
  logic [31:0] ALU_result;
  logic [31:0] opcplus4;
  logic        Jal;
  logic        RegWrite;
  logic        MemtoReg;
  logic        RegDst;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] Sign_extend;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [32];

  decode_32 dut (
    .clock       (clock),
    .reset       (reset),
    .Instruction (Instruction),
    .mem_data    (mem_data),
    .ALU_result  (ALU_result),
    .opcplus4    (opcplus4),
    .Jal         (Jal),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .Sign_extend (Sign_extend)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d);
    return {6'h00, s, t, d, 11'h000};
  endfunction

  // Destination and data chosen by the documented priority rules
  function automatic logic [4:0] tgt_addr();
    if (Jal) return 5'd31;
    return RegDst ? Instruction[15:11] : Instruction[20:16];
  endfunction

  function automatic logic [31:0] tgt_data();
    if (Jal) return opcplus4;
    return MemtoReg ? mem_data : ALU_result;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : model[a];
`ifdef DECODE32_BYPASS_EN
    if (reset && RegWrite && tgt_addr() != 5'd0 && tgt_addr() == a) v = tgt_data();
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_ext();
    int o;
    logic [15:0] i;
    o = int'(Instruction[31:26]);
    i = Instruction[15:0];
    if (o >= 11 && o <= 14) return {16'h0, i};
    return {{16{i[15]}}, i};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
    end else if (RegWrite && tgt_addr() != 5'd0) begin
      model[tgt_addr()] <= tgt_data();
    end
  end

  always @(negedge clock) begin
    check("model_rd1", read_data_1, exp_read(Instruction[25:21]));
    check("model_rd2", read_data_2, exp_read(Instruction[20:16]));
    check("model_ext", Sign_extend, exp_ext());
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; Jal = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    Instruction = rtype(5'd9, 5'd9, 5'd0);
    mem_data = 32'h0; ALU_result = 32'h0; opcplus4 = 32'h0;
    idle();
    RegWrite = 1'b1; RegDst = 1'b1; ALU_result = 32'hDEAD_BEEF;
    Instruction = rtype(5'd9, 5'd9, 5'd9);
    step(); step();
    check("reset_rd1", read_data_1, 32'h0);
    check("reset_rd2", read_data_2, 32'h0);
    idle();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ALU_result = 32'h1111_0000 + k;
      step();
    end
    check("idle_rd1", read_data_1, 32'h0);

    Instruction = 32'h3529_8000; #1 check("ori_ext", Sign_extend, 32'h0000_8000);
    Instruction = 32'h2129_8000; #1 check("addi_ext", Sign_extend, 32'hFFFF_8000);
    Instruction = 32'h3529_0000; #1 check("ori_zero", Sign_extend, 32'h0000_0000);
    Instruction = 32'h3129_FFFF; #1 check("andi_ext", Sign_extend, 32'h0000_FFFF);
    step();

    RegDst = 1'b1; RegWrite = 1'b1; ALU_result = 32'h1234_5678;
    Instruction = rtype(5'd0, 5'd0, 5'd5);
    step(); idle();
    Instruction = rtype(5'd5, 5'd0, 5'd0);
    #1 check("alu_wb", read_data_1, 32'h1234_5678);

    RegDst = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; mem_data = 32'hCAFE_0001;
    Instruction = rtype(5'd0, 5'd0, 5'd6);
    step(); idle();
    Instruction = rtype(5'd6, 5'd5, 5'd0);
    #1 check("mem_wb", read_data_1, 32'hCAFE_0001);
    check("mem_wb_keep5", read_data_2, 32'h1234_5678);

    Jal = 1'b1; RegWrite = 1'b1; RegDst = 1'b1; MemtoReg = 1'b1; opcplus4 = 32'h0000_0040;
    Instruction = rtype(5'd0, 5'd0, 5'd7);
    step(); idle();
    Instruction = rtype(5'd31, 5'd7, 5'd0);
    #1 check("jal_r31", read_data_1, 32'h0000_0040);
    check("jal_rd_untouched", read_data_2, 32'h0);

    Jal = 1'b1; opcplus4 = 32'h0000_0099;
    step(); idle();
    #1 check("jal_nowrite", read_data_1, 32'h0000_0040);

    RegDst = 1'b1; RegWrite = 1'b1; ALU_result = 32'hFFFF_FFFF;
    Instruction = rtype(5'd0, 5'd0, 5'd0);
    step(); idle();
    #1 check("r0_rd1", read_data_1, 32'h0);

    // RegDst=0: destination is rt
    RegWrite = 1'b1; ALU_result = 32'h0BAD_F00D;
    Instruction = {6'h08, 5'd0, 5'd10, 16'h0004};
    step(); idle();
    Instruction = rtype(5'd0, 5'd10, 5'd0);
    #1 check("rt_dst", read_data_2, 32'h0BAD_F00D);

    for (int k = 0; k < 8; k++) begin
      RegWrite = 1'b1; RegDst = k[0]; MemtoReg = k[1];
      ALU_result = $urandom; mem_data = $urandom;
      Instruction = $urandom;
      step();
    end
    idle();

    RegDst = 1'b1; RegWrite = 1'b1; ALU_result = 32'hA5A5_A5A5;
    Instruction = rtype(5'd9, 5'd9, 5'd9);
`ifdef DECODE32_BYPASS_EN
    #1 check("bypass_rd1", read_data_1, 32'hA5A5_A5A5);
`else
    #1 check("no_bypass_rd1", read_data_1, 32'h0);
`endif
    step(); idle();
    #1 check("r9_written", read_data_1, 32'hA5A5_A5A5);
    RegWrite = 1'b1; ALU_result = 32'h5A5A_5A5A;
    #1 reset = 1'b0;
    #1 check("midreset_rd1", read_data_1, 32'h0);
    check("midreset_rd2", read_data_2, 32'h0);
    step(); idle();
    reset = 1'b1;
    #1 check("after_release", read_data_1, 32'h0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
